csr_arbiter: RTL

CSR_ARBITER -- requirements
Module: csr_arbiter

---
 rtl/csr_arbiter_pkg.sv | 20 ++
 rtl/csr_arbiter_if.sv | 51 +++++
 rtl/csr_arbiter_rr_arb2.sv | 19 +
 rtl/csr_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/csr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// csr_arbiter_pkg : shared CSR-bus widths and arbiter state encodings
// Rev 1.0
// ============================================================================
package csr_arbiter_pkg;

    localparam int CSR_ADDR_W = 5;
    localparam int CSR_DATA_W = 8;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_ACCESS = 2'd1;
    localparam logic [ST_W-1:0] ST_ACK    = 2'd2;

    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/csr_arbiter_if.sv
`default_nettype none
// ============================================================================
// csr_arbiter_if : two CSR masters plus the register-file port of the arbiter
// Rev 1.0
// ============================================================================
interface csr_arbiter_if
    import csr_arbiter_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_W,
    parameter int DATA_W = CSR_DATA_W
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_a;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_a;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] csr_a;
    logic              csr_we;
    logic [DATA_W-1:0] csr_do;
    logic [DATA_W-1:0] csr_di;

    // arbiter side
    modport slave (
        input  m0_req, m0_we, m0_a, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_a, m1_wdata,
        output m1_ack, m1_rdata,
        output csr_a, csr_we, csr_do,
        input  csr_di
    );

    // requesters and register file side
    modport master (
        output m0_req, m0_we, m0_a, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_a, m1_wdata,
        input  m1_ack, m1_rdata,
        input  csr_a, csr_we, csr_do,
        output csr_di
    );
endinterface
`default_nettype wire

// File: rtl/csr_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-way round-robin grant, combinational, one-hot output
// Rev 1.0
// ============================================================================
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);
    // last = 1 means master 1 was granted most recently, so master 0 wins ties
    always_comb begin
        grant    = 2'b00;
        grant[0] = req0 & (~req1 | last);
        grant[1] = req1 & (~req0 | ~last);
    end
endmodule
`default_nettype wire

// File: rtl/csr_arbiter.sv
`default_nettype none
// ============================================================================
// csr_arbiter : two-master round-robin arbiter onto a single CSR register file
// Rev 1.0
// ============================================================================
module csr_arbiter
    import csr_arbiter_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_W,
    parameter int DATA_W = CSR_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    csr_arbiter_if.slave  bus
);
    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nxt;
    logic              r_last;
    logic              r_id;
    logic              r_we;
    logic [1:0]        w_grant;
    logic              w_win_id;
    logic              w_start;

    logic [ADDR_W-1:0] r_csr_a;
    logic [DATA_W-1:0] r_csr_do;
    logic              r_csr_we;
    logic [1:0]        r_ack;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    logic [ADDR_W-1:0] w_csr_a_nxt;
    logic [DATA_W-1:0] w_csr_do_nxt;
    logic              w_csr_we_nxt;
    logic [1:0]        w_ack_nxt;
    logic              w_capture;

    rr_arb2 u_rr_arb2 (
        .req0  (bus.m0_req),
        .req1  (bus.m1_req),
        .last  (r_last),
        .grant (w_grant)
    );

    assign w_win_id = w_grant[1];
    assign w_start  = (r_state == ST_IDLE) && (w_grant != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant != 2'b00) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_ACK;
            ST_ACK:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; the bus only carries data in ACCESS
    always_comb begin
        w_csr_a_nxt  = '0;
        w_csr_do_nxt = '0;
        w_csr_we_nxt = 1'b0;
        w_ack_nxt    = 2'b00;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant != 2'b00) begin
                    w_csr_a_nxt  = w_win_id ? bus.m1_a     : bus.m0_a;
                    w_csr_do_nxt = w_win_id ? bus.m1_wdata : bus.m0_wdata;
                    w_csr_we_nxt = w_win_id ? bus.m1_we    : bus.m0_we;
                end
            end
            ST_ACCESS: begin
                w_ack_nxt[r_id] = 1'b1;
                w_capture       = ~r_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= MID_M1;
            r_id       <= MID_M0;
            r_we       <= 1'b0;
            r_csr_a    <= '0;
            r_csr_do   <= '0;
            r_csr_we   <= 1'b0;
            r_ack      <= 2'b00;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            r_csr_a  <= w_csr_a_nxt;
            r_csr_do <= w_csr_do_nxt;
            r_csr_we <= w_csr_we_nxt;
            r_ack    <= w_ack_nxt;
            if (w_start) begin
                r_id   <= w_win_id;
                r_we   <= w_csr_we_nxt;
                r_last <= w_win_id;
            end
            if (w_capture) begin
                if (r_id == MID_M1) r_m1_rdata <= bus.csr_di;
                else                r_m0_rdata <= bus.csr_di;
            end
        end
    end

    assign bus.csr_a    = r_csr_a;
    assign bus.csr_do   = r_csr_do;
    assign bus.csr_we   = r_csr_we;
    assign bus.m0_ack   = r_ack[0];
    assign bus.m1_ack   = r_ack[1];
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire
